indicator_flasher: RTL and testbench

Multi-channel turn/indicator light driver for the car body-control path. Each of `NCH` lamp outputs is independently off, steady, following a flash request, or running a fixed-count "comfort" blink sequence. A flash restarts its phase on every new request, so the lamp always comes on immediately. An optional hazard input forces all channels to flash in a common phase. It sits between the drive-state decoder and the lamp pins and generalises the single-lamp flasher to N channels with configurable period and modes.

---
 rtl/indicator_pkg.sv | 15 +
 rtl/flash_phase_gen.sv | 51 +++++
 rtl/indicator_flasher.sv | 161 ++++++++++++++++
 tb/tb_indicator_flasher.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/indicator_pkg.sv
// Shared mode encodings and per-channel FSM state type for the indicator flasher.
package indicator_pkg;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_STEADY  = 2'd1;
    localparam logic [1:0] MODE_FOLLOW  = 2'd2;
    localparam logic [1:0] MODE_COMFORT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ON_PH  = 2'd1,
        ST_OFF_PH = 2'd2
    } ch_state_e;

endpackage

// File: rtl/flash_phase_gen.sv
// Half-period phase counter with an on/off toggle; restart forces a fresh on-phase.
module flash_phase_gen #(
    parameter int HALF_PERIOD = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic restart_i,
    output logic phase_on_o,
    output logic phase_end_o
);

    localparam int              CW   = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0]   LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          on_q, on_d;

    assign phase_end_o = run_i & ~restart_i & (cnt_q == LAST);
    assign phase_on_o  = on_q;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        cnt_d = cnt_q;
        on_d  = on_q;
        if (restart_i) begin
            cnt_d = '0;
            on_d  = 1'b1;
        end else if (!run_i) begin
            cnt_d = '0;
            on_d  = 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            on_d  = ~on_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            on_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            on_q  <= on_d;
        end
    end

endmodule

// File: rtl/indicator_flasher.sv
// N-channel indicator driver: OFF/STEADY/FOLLOW/COMFORT per channel.
// Optional common-phase hazard flashing when INDICATOR_HAZARD_EN is defined.
module indicator_flasher
    import indicator_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int HALF_PERIOD = 50_000_000,
    parameter int BLINKS      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2*NCH-1:0] mode,
    input  logic [NCH-1:0]   req,
`ifdef INDICATOR_HAZARD_EN
    input  logic             hazard,
`endif
    output logic [NCH-1:0]   light,
    output logic [NCH-1:0]   busy
);

    localparam int            BW       = $clog2(BLINKS + 1);
    localparam logic [BW-1:0] BLINKS_C = BW'(BLINKS);

    logic [NCH-1:0] req_q;
    logic           hold;
    logic           hz_light_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_q <= '0;
        else        req_q <= req;
    end

`ifdef INDICATOR_HAZARD_EN
    logic hazard_q, hz_rise, hz_on, hz_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hazard_q <= 1'b0;
        else        hazard_q <= hazard;
    end

    assign hz_rise = hazard & ~hazard_q;

    flash_phase_gen #(.HALF_PERIOD(HALF_PERIOD)) u_hazard_phase (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (hazard),
        .restart_i   (hz_rise),
        .phase_on_o  (hz_on),
        .phase_end_o (hz_end)
    );

    assign hold       = hazard;
    assign hz_light_d = hz_rise | (hz_on ^ hz_end);
`else
    assign hold       = 1'b0;
    assign hz_light_d = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_e     state_q, state_d;
        logic [BW-1:0] blink_q, blink_d;
        logic          light_q, light_d, busy_q, busy_d;
        logic          restart, rise, flashing, phase_on, phase_end;
        logic [1:0]    ch_mode;

        assign ch_mode  = mode[2*i +: 2];
        assign rise     = req[i] & ~req_q[i];
        assign flashing = (state_q != ST_IDLE);

        flash_phase_gen #(.HALF_PERIOD(HALF_PERIOD)) u_phase (
            .clk         (clk),
            .rst_n       (rst_n),
            .run_i       (flashing),
            .restart_i   (restart),
            .phase_on_o  (phase_on),
            .phase_end_o (phase_end)
        );

        always_comb begin
            state_d = state_q;
            blink_d = blink_q;
            light_d = light_q;
            busy_d  = busy_q;
            restart = 1'b0;
            if (hold) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                light_d = hz_light_d;
            end else begin
                case (ch_mode)
                    MODE_OFF: begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        light_d = 1'b0;
                    end
                    MODE_STEADY: begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        light_d = 1'b1;
                    end
                    MODE_FOLLOW: begin
                        busy_d = 1'b0;
                        // busy_q set means a comfort sequence owns the phase: take over afresh.
                        if (!req[i]) begin
                            state_d = ST_IDLE;
                            light_d = 1'b0;
                        end else if (!flashing || busy_q || rise) begin
                            restart = 1'b1;
                        end else if (phase_end) begin
                            state_d = (state_q == ST_ON_PH) ? ST_OFF_PH : ST_ON_PH;
                            light_d = ~phase_on;
                        end
                    end
                    MODE_COMFORT: begin
                        if (rise) begin
                            restart = 1'b1;
                            blink_d = BW'(1);
                            busy_d  = 1'b1;
                        end else if (!busy_q || !flashing) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            light_d = 1'b0;
                        end else if (phase_end) begin
                            if (state_q == ST_OFF_PH && blink_q == BLINKS_C) begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                                light_d = 1'b0;
                            end else begin
                                state_d = (state_q == ST_ON_PH) ? ST_OFF_PH : ST_ON_PH;
                                light_d = ~phase_on;
                                if (state_q == ST_OFF_PH) blink_d = blink_q + BW'(1);
                            end
                        end
                    end
                endcase
            end
            if (restart) begin
                state_d = ST_ON_PH;
                light_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                blink_q <= '0;
                light_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                blink_q <= blink_d;
                light_q <= light_d;
                busy_q  <= busy_d;
            end
        end

        assign light[i] = light_q;
        assign busy[i]  = busy_q;
    end

endmodule

// File: tb/tb_indicator_flasher.sv
// Self-checking bench for indicator_flasher (HALF_PERIOD=4, BLINKS=3, NCH=2).
// Hazard scenarios are exercised when INDICATOR_HAZARD_EN is defined.
module tb_indicator_flasher;
    import indicator_pkg::*;

    localparam int NCH = 2;
    localparam int HP  = 4;
    localparam int BL  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   light;
    logic [NCH-1:0]   busy;
`ifdef INDICATOR_HAZARD_EN
    logic             hazard;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    indicator_flasher #(.NCH(NCH), .HALF_PERIOD(HP), .BLINKS(BL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (mode),
        .req    (req),
`ifdef INDICATOR_HAZARD_EN
        .hazard (hazard),
`endif
        .light  (light),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Reference model: each flashing channel remembers the cycle its phase started;
    // the lamp is on during even-numbered half periods since then.
    int             cyc;
    int             m_start  [NCH];
    bit             m_active [NCH];
    bit             m_comfort[NCH];
    logic [NCH-1:0] m_light, m_busy, m_prev_req;
    bit             m_hz_prev;
    int             m_hz_start;

    function automatic bit phase_lit(int now, int start);
        return ((now - start) / HP) % 2 == 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_active[c]  = 0;
            m_comfort[c] = 0;
            m_start[c]   = 0;
        end
        m_light    = '0;
        m_busy     = '0;
        m_prev_req = '0;
        m_hz_prev  = 0;
        m_hz_start = 0;
    endtask

    task automatic model_step();
        bit hz;
        cyc++;
        hz = 0;
`ifdef INDICATOR_HAZARD_EN
        hz = hazard;
`endif
        if (hz) begin
            if (!m_hz_prev) m_hz_start = cyc;
            for (int c = 0; c < NCH; c++) begin
                m_active[c] = 0;
                m_light[c]  = phase_lit(cyc, m_hz_start);
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bit r, rise;
                r    = req[c];
                rise = r && !m_prev_req[c];
                case (mode[2*c +: 2])
                    MODE_OFF:    begin m_active[c] = 0; m_light[c] = 0; end
                    MODE_STEADY: begin m_active[c] = 0; m_light[c] = 1; end
                    MODE_FOLLOW: begin
                        if (!r) begin
                            m_active[c] = 0;
                        end else if (!m_active[c] || m_comfort[c] || rise) begin
                            m_active[c] = 1; m_comfort[c] = 0; m_start[c] = cyc;
                        end
                        m_light[c] = m_active[c] && phase_lit(cyc, m_start[c]);
                    end
                    default: begin
                        if (rise) begin
                            m_active[c] = 1; m_comfort[c] = 1; m_start[c] = cyc;
                        end else if (!m_active[c] || !m_comfort[c]
                                     || cyc - m_start[c] >= 2 * BL * HP) begin
                            m_active[c] = 0;
                        end
                        m_light[c] = m_active[c] && phase_lit(cyc, m_start[c]);
                    end
                endcase
            end
        end
        for (int c = 0; c < NCH; c++) m_busy[c] = m_active[c] && m_comfort[c];
        m_hz_prev  = hz;
        m_prev_req = req;
    endtask

    // One clock: inputs are stable at the posedge, outputs are sampled on the negedge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        mode  = '0;
        req   = '0;
`ifdef INDICATOR_HAZARD_EN
        hazard = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (light !== 2'b00 || busy !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_held: light=%b busy=%b want 00/00", light, busy);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (light !== 2'b00 || busy !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release: light=%b busy=%b want 00/00", light, busy);
        end
        mode[1:0] = MODE_STEADY;
        step();
        n_cmp++;
        if (light !== 2'b01) begin
            n_bad++;
            $display("FAIL steady_on: light=%b want 01", light);
        end
    endtask

    task automatic test_follow();
        bit exp_pat[12] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        mode = {MODE_OFF, MODE_FOLLOW};
        req  = 2'b00;
        step();
        req = 2'b01;
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (light[0] !== exp_pat[i] || light[0] !== m_light[0]) begin
                n_bad++;
                $display("FAIL follow_wave[%0d]: light0=%b want %b", i, light[0], exp_pat[i]);
            end
        end
        req = 2'b00;
        step();
        n_cmp++;
        if (light !== 2'b00) begin
            n_bad++;
            $display("FAIL follow_drop: light=%b want 00", light);
        end
    endtask

    task automatic test_follow_restart();
        int highs;
        mode = {MODE_OFF, MODE_FOLLOW};
        req  = 2'b01;
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (light[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_in_off: light0=%b want 0", light[0]);
        end
        req = 2'b00;
        step();
        n_cmp++;
        if (light[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_gap: light0=%b want 0", light[0]);
        end
        req   = 2'b01;
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (light[0] === 1'b1 && highs == i) highs++;
        end
        n_cmp++;
        if (highs != HP || light[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_high_phase: high run=%0d last=%b want %0d then 0",
                     highs, light[0], HP);
        end
    endtask

    task automatic test_comfort();
        int busy_cnt, ons, last_busy;
        logic prev;
        mode = {MODE_COMFORT, MODE_OFF};
        req  = 2'b00;
        step();
        busy_cnt = 0; ons = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            req[1] = (i == 0);
            step();
            if (busy[1] === 1'b1) busy_cnt++;
            if (light[1] === 1'b1 && prev === 1'b0) ons++;
            prev = light[1];
            n_cmp++;
            if (light !== m_light || busy !== m_busy) begin
                n_bad++;
                $display("FAIL comfort_model[%0d]: light=%b busy=%b want %b/%b",
                         i, light, busy, m_light, m_busy);
            end
        end
        n_cmp++;
        if (busy_cnt != 2 * BL * HP || ons != BL || light[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL comfort_single: busy cycles=%0d on-phases=%0d light1=%b want %0d/%0d/0",
                     busy_cnt, ons, light[1], 2 * BL * HP, BL);
        end
        busy_cnt = 0; last_busy = -1;
        for (int i = 0; i < 50; i++) begin
            req[1] = (i == 0 || i == 10);
            step();
            if (busy[1] === 1'b1) begin busy_cnt++; last_busy = i; end
        end
        n_cmp++;
        if (busy_cnt != 10 + 2 * BL * HP || last_busy != 9 + 2 * BL * HP) begin
            n_bad++;
            $display("FAIL comfort_retrigger: busy cycles=%0d last=%0d want %0d/%0d",
                     busy_cnt, last_busy, 10 + 2 * BL * HP, 9 + 2 * BL * HP);
        end
        req = 2'b00;
    endtask

    task automatic test_reset_mid_phase();
        mode = {MODE_OFF, MODE_FOLLOW};
        req  = 2'b00;
        step();
        req = 2'b01;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (light !== 2'b00 || busy !== 2'b00) begin
            n_bad++;
            $display("FAIL async_reset: light=%b busy=%b want 00/00", light, busy);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (light !== 2'b01) begin
            n_bad++;
            $display("FAIL req_through_reset: light=%b want 01", light);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (light !== m_light) begin
                n_bad++;
                $display("FAIL post_reset_wave[%0d]: light=%b want %b", i, light, m_light);
            end
        end
    endtask

`ifdef INDICATOR_HAZARD_EN
    task automatic test_hazard();
        mode = {MODE_OFF, MODE_FOLLOW};
        req  = 2'b00;
        step();
        req = 2'b01;
        for (int i = 0; i < 3; i++) step();
        hazard = 1'b1;
        step();
        n_cmp++;
        if (light !== 2'b11 || busy !== 2'b00) begin
            n_bad++;
            $display("FAIL hazard_rise: light=%b busy=%b want 11/00", light, busy);
        end
        for (int i = 0; i < 9; i++) begin
            step();
            n_cmp++;
            if (light[0] !== light[1] || light !== m_light) begin
                n_bad++;
                $display("FAIL hazard_lockstep[%0d]: light=%b want %b", i, light, m_light);
            end
        end
        hazard = 1'b0;
        step();
        n_cmp++;
        if (light !== 2'b01) begin
            n_bad++;
            $display("FAIL hazard_fall: light=%b want 01", light);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (light !== ((i < 3) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL hazard_fall_phase[%0d]: light=%b want %b",
                         i, light, (i < 3) ? 2'b01 : 2'b00);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(39) == 0) mode[2*c +: 2] = 2'($urandom_range(3));
                if ($urandom_range(5) == 0)  req[c] = ~req[c];
            end
`ifdef INDICATOR_HAZARD_EN
            if ($urandom_range(79) == 0) hazard = ~hazard;
`endif
            step();
            n_cmp++;
            if (light !== m_light || busy !== m_busy) begin
                n_bad++;
                $display("FAIL random[%0d]: mode=%b req=%b light=%b busy=%b want %b/%b",
                         n, mode, req, light, busy, m_light, m_busy);
            end
        end
`ifdef INDICATOR_HAZARD_EN
        hazard = 1'b0;
`endif
    endtask

    initial begin
        cyc = 0;
        model_reset();
        test_reset();
        test_follow();
        test_follow_restart();
        test_comfort();
        test_reset_mid_phase();
`ifdef INDICATOR_HAZARD_EN
        test_hazard();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
